// File: rtl/mic_adc_reader.sv
// SPI master for a 12-bit ADCS7476-style microphone ADC.
// Periodic 16-SCLK frames, MSB first, registered sample with valid strobe.
module mic_adc_reader #(
    parameter int HALF_DIV      = 4,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic [DATA_BITS-1:0] mic,
    output logic                 mic_valid,
    output logic                 frame_err
);
    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = $clog2(HALF_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
    localparam logic [BW-1:0] BIT_ALL  = BW'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         per_q, per_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0]  mic_q, mic_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  vld_q, vld_d;
    logic                  err_q, err_d;
    logic                  start;
    logic                  div_end;

    assign start   = enable && (per_q == '0);
    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        per_d = '0;
        if (enable) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        mic_d   = mic_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                sclk_d = 1'b1;
                cs_n_d = 1'b1;
                if (start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // ADC data is stable before our rising edge
                        sclk_d = 1'b1;
                        sh_d   = {sh_q[FRAME_BITS-2:0], miso};
                        bit_d  = bit_q + 1'b1;
                    end else if (bit_q == BIT_ALL) begin
                        state_d = DONE;
                        cs_n_d  = 1'b1;
                        vld_d   = 1'b1;
                        mic_d   = sh_q[DATA_BITS-1:0];
                        err_d   = |sh_q[FRAME_BITS-1:DATA_BITS];
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            mic_q   <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            mic_q   <= mic_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign mic       = mic_q;
    assign mic_valid = vld_q;
    assign frame_err = err_q;
endmodule
